// File: rtl/nv_nvdla_ram_fifo_ctrl_128x257_pkg.sv
// Shared NVDLA RAM constants for the 128x257 FIFO controller and its RAM.
// Pointers carry one extra wrap bit above the RAM address.
package nv_nvdla_ram_fifo_ctrl_128x257_pkg;

  localparam int unsigned RAM_DEPTH = 128;
  localparam int unsigned RAM_DW    = 257;
  localparam int unsigned RAM_AW    = 7;
  localparam int unsigned RAM_PW    = 8;

  typedef logic [RAM_PW-1:0] ptr_t;
  typedef logic [RAM_AW-1:0] addr_t;

  // Conditional pointer advance; the wrap bit rolls over naturally at 256.
  function automatic ptr_t ptrNext(input ptr_t p, input logic en);
    return p + ptr_t'(en);
  endfunction

  function automatic addr_t ptrAddr(input ptr_t p);
    return p[RAM_AW-1:0];
  endfunction

endpackage

// File: rtl/nv_nvdla_ram_fifo_ctrl_128x257_if.sv
// Push/pop handshakes plus the RAM write and read ports of the FIFO controller.
// The slave modport is the controller; master is the surrounding parent.
interface nv_nvdla_ram_fifo_ctrl_128x257_if
  import nv_nvdla_ram_fifo_ctrl_128x257_pkg::*;
  #(parameter int DW = RAM_DW) ();

  logic              wr_pvld;
  logic              wr_prdy;
  logic [DW-1:0]     wr_pd;

  logic              rd_pvld;
  logic              rd_prdy;
  logic [DW-1:0]     rd_pd;

  logic              ram_we;
  logic [RAM_AW-1:0] ram_wa;
  logic [DW-1:0]     ram_di;

  logic              ram_re;
  logic [RAM_AW-1:0] ram_ra;
  logic              ram_ore;
  logic [DW-1:0]     ram_dout;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd,
    output ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_ore
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd,
    input  ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_ore
  );

endinterface

// File: rtl/nv_nvdla_ram_fifo_ctrl_128x257.sv
// FIFO controller for a 128x257 RAM with 2-cycle read latency (re, then ore).
// Entries stay owned by the FIFO until popped, so in-flight reads are never overwritten.
module nv_nvdla_ram_fifo_ctrl_128x257
  import nv_nvdla_ram_fifo_ctrl_128x257_pkg::*;
  #(
    parameter int DEPTH = RAM_DEPTH,
    parameter int DW    = RAM_DW
  ) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    nv_nvdla_ram_fifo_ctrl_128x257_if.slave io_fifo,
    input  logic [31:0]          pwrbus_ram_pd,
    output logic [31:0]          ram_pwrbus_pd,
    output logic [RAM_PW-1:0]    fifo_count,
    output logic                 fifo_idle
  );

  ptr_t r_wrPtr;
  ptr_t r_issPtr;
  ptr_t r_popPtr;
  logic r_v1;
  logic r_v2;

  ptr_t          w_count;
  logic          w_wrPrdy;
  logic          w_push;
  logic          w_pop;
  logic          w_s1Free;
  logic          w_s2Free;
  logic          w_ramRe;
  logic          w_ramOre;
  logic [DW-1:0] w_ramDi;
  logic [DW-1:0] w_rdPd;

  // Occupancy counts from the pop pointer, so issued-but-unpopped entries stay reserved.
  assign w_count  = r_wrPtr - r_popPtr;
  assign w_wrPrdy = (w_count < ptr_t'(DEPTH));
  assign w_push   = io_fifo.wr_pvld && w_wrPrdy;
  assign w_pop    = r_v2 && io_fifo.rd_prdy;

  assign w_s2Free = !r_v2 || io_fifo.rd_prdy;
  assign w_ramOre = r_v1 && w_s2Free;
  assign w_s1Free = !r_v1 || w_ramOre;
  assign w_ramRe  = (r_issPtr != r_wrPtr) && w_s1Free;

  assign w_ramDi  = io_fifo.wr_pd;
  assign w_rdPd   = io_fifo.ram_dout;

  assign io_fifo.wr_prdy = w_wrPrdy;
  assign io_fifo.ram_we  = w_push;
  assign io_fifo.ram_wa  = ptrAddr(r_wrPtr);
  assign io_fifo.ram_di  = w_ramDi;
  assign io_fifo.ram_re  = w_ramRe;
  assign io_fifo.ram_ra  = ptrAddr(r_issPtr);
  assign io_fifo.ram_ore = w_ramOre;
  assign io_fifo.rd_pvld = r_v2;
  assign io_fifo.rd_pd   = w_rdPd;

  assign fifo_count    = w_count;
  assign fifo_idle     = (w_count == '0) && !r_v1 && !r_v2;
  assign ram_pwrbus_pd = pwrbus_ram_pd;

  // v1 = address latched in RAM, v2 = data parked in the RAM output register.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_wrPtr  <= '0;
      r_issPtr <= '0;
      r_popPtr <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
    end else begin
      r_wrPtr  <= ptrNext(r_wrPtr, w_push);
      r_issPtr <= ptrNext(r_issPtr, w_ramRe);
      r_popPtr <= ptrNext(r_popPtr, w_pop);
      r_v1     <= w_ramRe || (r_v1 && !w_ramOre);
      r_v2     <= w_ramOre || (r_v2 && !io_fifo.rd_prdy);
    end
  end

endmodule

// File: doc/nv_nvdla_ram_fifo_ctrl_128x257.md
NV_NVDLA_RAM_FIFO_CTRL_128X257 -- requirements
Module: nv_nvdla_ram_fifo_ctrl_128x257

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, meaning number of RAM entries.
REQ-002 The block SHALL have parameter DW, default 257, meaning payload width.
REQ-003 The block SHALL have port nvdla_core_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port nvdla_core_rstn, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have ports wr_pvld (input, 1), wr_prdy (output, 1) and wr_pd (input, DW) as the push handshake.
REQ-006 The block SHALL have ports rd_pvld (output, 1), rd_prdy (input, 1) and rd_pd (output, DW) as the pop handshake.
REQ-007 The block SHALL drive the RAM write port through ram_we (output, 1), ram_wa (output, 7) and ram_di (output, DW).
REQ-008 The block SHALL drive the RAM read port through ram_re (output, 1), ram_ra (output, 7) and ram_ore (output, 1), and SHALL receive ram_dout (input, DW).
REQ-009 The block SHALL have output fifo_count, 8 bits, giving the number of occupied entries, and output fifo_idle, 1 bit.
REQ-010 The block SHALL pass input pwrbus_ram_pd (32 bits) unchanged to output ram_pwrbus_pd (32 bits).

Function
REQ-011 The RAM model SHALL be treated as having 2-cycle read latency: re registers ra at cycle N, and ore at cycle N+1 registers data that is visible at cycle N+2.
REQ-012 The block SHALL keep three 8-bit pointers (wr_ptr, iss_ptr, pop_ptr); bits [6:0] address the RAM, and bit 7 is the wrap bit.
REQ-013 A push occurs when wr_pvld && wr_prdy; the block SHALL then drive ram_we=1, ram_wa=wr_ptr[6:0] and ram_di=wr_pd in the same cycle, and increment wr_ptr.
REQ-014 fifo_count SHALL equal wr_ptr-pop_ptr (mod 256), with range 0..128.
REQ-015 wr_prdy SHALL be 1 exactly when fifo_count<128, and SHALL NOT depend combinationally on rd_prdy.
REQ-016 Pipeline stage valids v1 (address issued) and v2 (data held in the RAM output register) SHALL be registers.
REQ-017 s2_free SHALL be !v2 || rd_prdy; ram_ore SHALL be v1 && s2_free.
REQ-018 s1_free SHALL be !v1 || ram_ore; ram_re SHALL be (iss_ptr!=wr_ptr) && s1_free, with ram_ra=iss_ptr[6:0], and iss_ptr SHALL increment on ram_re.
REQ-019 rd_pvld SHALL equal v2, and rd_pd SHALL equal ram_dout.
REQ-020 A pop occurs when rd_pvld && rd_prdy; pop_ptr SHALL increment only on a pop, so a RAM slot is freed only when popped and can never be overwritten while in flight.
REQ-021 When rd_pvld && !rd_prdy, ram_ore SHALL be 0 and rd_pd SHALL be held stable.
REQ-022 Write-to-read latency SHALL be: push at cycle N, ram_re at N+1, ram_ore at N+2, rd_pvld at N+3.
REQ-023 With rd_prdy held at 1 and data available, the block SHALL sustain one pop per cycle.
REQ-024 A simultaneous push and pop SHALL leave fifo_count unchanged; at full, a same-cycle pop does not raise wr_prdy until the next cycle.
REQ-025 fifo_idle SHALL be (fifo_count==0) && !v1 && !v2.

Reset
REQ-026 On nvdla_core_rstn=0 at a clock edge, all pointers, v1 and v2 SHALL clear to 0.
REQ-027 Outputs SHALL read after reset: wr_prdy=1, rd_pvld=0, ram_we=0, ram_re=0, ram_ore=0, fifo_count=0, fifo_idle=1.
REQ-028 A reset mid-operation SHALL discard all queued and in-flight entries; RAM contents are not cleared.

Structure
REQ-029 DEPTH, DW, the address width (7) and the pointer width (8) SHALL be constants in the shared NVDLA RAM package.
REQ-030 No sub-module SHALL be used; the parent instantiates nv_ram_rwsp_128x257 beside this block and connects the ram_* ports.

Verification
REQ-031 Bench SHALL cover: single push of 0x1_AAAA...A at cycle 0 with rd_prdy=1 -> ram_re at cycle 1, ram_ore at cycle 2, rd_pvld=1 with matching rd_pd at cycle 3, fifo_idle=1 at cycle 4.
REQ-032 Bench SHALL cover: 128 pushes with rd_prdy=0 -> fifo_count=128 and wr_prdy=0; the 129th push is not accepted; v1=v2=1 holding entry 0.
REQ-033 Bench SHALL cover: at full, rd_prdy=1 for one cycle -> entry 0 popped, wr_prdy=1 next cycle, and a new push lands at ram_wa=0.
REQ-034 Bench SHALL cover: continuous push and pop of an incrementing pattern for 300 cycles -> in-order data, no loss, one pop per cycle after fill, pointers wrap through 255->0.
REQ-035 Bench SHALL cover: rd_prdy toggling randomly -> rd_pd stable while stalled and ram_ore=0 during stalls.
REQ-036 Bench SHALL cover: reset asserted with 5 entries queued and v1=v2=1 -> next cycle rd_pvld=0, fifo_count=0, wr_prdy=1.
